// File: rtl/exec_ctrl.sv
// exec_ctrl: four-phase sequencing controller in front of a 32x16 register
// file. Takes one instruction per handshake, reads both source registers,
// runs a 16-bit ALU operation, writes the result back and keeps the
// {N, Z, F, C} flag register.
module exec_ctrl #(
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [23:0] instr,
  output logic        instr_ready,
  output logic [4:0]  reg_index1,
  output logic [4:0]  reg_index2,
  input  logic [15:0] reg_data1,
  input  logic [15:0] reg_data2,
  output logic [4:0]  w_index,
  output logic [15:0] w_data,
  output logic        w_enable,
  output logic [3:0]  flags,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR  = 4'd4;
  localparam logic [OPW-1:0] OP_MOV  = 4'd5;
  localparam logic [OPW-1:0] OP_ADDI = 4'd6;
  localparam logic [OPW-1:0] OP_MOVI = 4'd7;
  localparam logic [OPW-1:0] OP_LSH  = 4'd8;
  localparam logic [OPW-1:0] OP_CMP  = 4'd9;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic           accept;

  // Latched instruction fields; the reserved bits are never stored.
  logic [OPW-1:0] ir_op;
  logic [4:0]     ir_rd;
  logic [4:0]     ir_rs;
  logic [7:0]     ir_imm;

  logic [15:0]    opa;
  logic [15:0]    opb;
  logic [15:0]    result;

  logic [16:0]    sum17;
  logic [15:0]    alu_res;
  logic           alu_carry;
  logic           alu_ovf;
  logic           alu_we;
  logic           alu_upd;
  logic [15:0]    imm_sext;
  logic [3:0]     alu_flags;

  logic           unused_rsvd;

  assign unused_rsvd = ^instr[9:8];

  assign accept = (state == S_IDLE) && instr_valid && instr_ready;

  // Read indices and write index come straight from the latched
  // instruction, so they hold through EXEC and WRITE until the next accept.
  assign reg_index1 = ir_rd;
  assign reg_index2 = ir_rs;
  assign w_index    = ir_rd;
  assign w_data     = result;

  // Next-state logic: only IDLE waits, every other phase advances.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = accept ? S_READ : S_IDLE;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready is registered so it stays low in reset and rises one edge after
  // release; it is high exactly when the machine will sit in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready <= 1'b0;
    end else begin
      instr_ready <= (state_next == S_IDLE);
    end
  end

  // Capture the instruction on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_op  <= '0;
      ir_rd  <= '0;
      ir_rs  <= '0;
      ir_imm <= '0;
    end else if (accept) begin
      ir_op  <= instr[23:20];
      ir_rd  <= instr[19:15];
      ir_rs  <= instr[14:10];
      ir_imm <= instr[7:0];
    end
  end

  // Capture the combinational register-file read data at the end of READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
    end else if (state == S_READ) begin
      opa <= reg_data1;
      opb <= reg_data2;
    end
  end

  // ALU: result, carry/borrow, signed overflow and the writeback and
  // flag-update qualifiers for the current opcode.
  always_comb begin
    imm_sext  = {{8{ir_imm[7]}}, ir_imm};
    sum17     = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_we    = 1'b1;
    alu_upd   = 1'b0;
    case (ir_op)
      OP_ADD: begin
        sum17     = {1'b0, opa} + {1'b0, opb};
        alu_res   = sum17[15:0];
        alu_carry = sum17[16];
        alu_ovf   = (opa[15] == opb[15]) && (alu_res[15] != opa[15]);
        alu_upd   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        sum17     = {1'b0, opa} - {1'b0, opb};
        alu_res   = sum17[15:0];
        alu_carry = sum17[16];
        alu_ovf   = (opa[15] != opb[15]) && (alu_res[15] != opa[15]);
        alu_upd   = 1'b1;
        alu_we    = (ir_op == OP_SUB);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MOV:  alu_res = opb;
      OP_ADDI: begin
        sum17     = {1'b0, opa} + {1'b0, imm_sext};
        alu_res   = sum17[15:0];
        alu_carry = sum17[16];
        alu_ovf   = (opa[15] == imm_sext[15]) && (alu_res[15] != opa[15]);
        alu_upd   = 1'b1;
      end
      OP_MOVI: alu_res = {8'h00, ir_imm};
      OP_LSH:  alu_res = opa << opb[3:0];
      default: alu_we  = 1'b0;
    endcase
    alu_flags = {alu_res[15], (alu_res == 16'd0), alu_ovf, alu_carry};
  end

  // Register the result and flags at the end of EXEC; non-flag opcodes
  // leave the flag register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (state == S_EXEC) begin
      if (alu_we) begin
        result <= alu_res;
      end
      if (alu_upd) begin
        flags <= alu_flags;
      end
    end
  end

  // One-cycle write strobe and retire pulse, both asserted during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_enable <= 1'b0;
      done     <= 1'b0;
    end else begin
      w_enable <= (state == S_EXEC) && alu_we;
      done     <= (state == S_EXEC);
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: a behavioural register file plus an
// arithmetic reference model of the instruction set, driven with directed
// and random instructions.
module tb_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [23:0] instr;
  logic        instr_ready;
  logic [4:0]  reg_index1;
  logic [4:0]  reg_index2;
  logic [15:0] reg_data1;
  logic [15:0] reg_data2;
  logic [4:0]  w_index;
  logic [15:0] w_data;
  logic        w_enable;
  logic [3:0]  flags;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rf [32];
  logic [15:0] model_rf [32];
  logic [3:0]  model_flags;
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [15:0] pl_val;
  logic [15:0] obs_wdata;
  logic [3:0]  obs_flags;

  exec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .reg_index1 (reg_index1),
    .reg_index2 (reg_index2),
    .reg_data1  (reg_data1),
    .reg_data2  (reg_data2),
    .w_index    (w_index),
    .w_data     (w_data),
    .w_enable   (w_enable),
    .flags      (flags),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file: DUT writes plus bench preloads.
  always @(posedge clk) begin
    if (w_enable) rf[w_index] <= w_data;
    if (pl_en) rf[pl_idx] <= pl_val;
  end

  assign reg_data1 = rf[reg_index1];
  assign reg_data2 = rf[reg_index2];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] mk(input int op, input int rd, input int rs, input int rsv, input int imm);
    logic [3:0] o;
    logic [4:0] d;
    logic [4:0] s;
    logic [1:0] r;
    logic [7:0] i;
    o = op[3:0];
    d = rd[4:0];
    s = rs[4:0];
    r = rsv[1:0];
    i = imm[7:0];
    return {o, d, s, r, i};
  endfunction

  // Instruction semantics from plain integer arithmetic: unsigned range for
  // carry/borrow, signed range for overflow.
  function automatic void refModel(input int op, input int a, input int b, input int imm,
                                   input logic [3:0] fin, output logic [15:0] res,
                                   output bit we, output logic [3:0] fout);
    int s, ss, sa, sb, simm, r;
    bit upd, n, z, f, c;
    s = 0; ss = 0; upd = 0; c = 0; we = 1;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    simm = (imm >= 128) ? imm - 256 : imm;
    case (op)
      0: begin s = a + b; ss = sa + sb; c = (s > 65535); upd = 1; end
      1: begin s = a - b; ss = sa - sb; c = (a < b); upd = 1; end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = b;
      6: begin s = a + (simm + 65536) % 65536; ss = sa + simm; c = (s > 65535); upd = 1; end
      7: s = imm;
      8: s = a << (b % 16);
      9: begin s = a - b; ss = sa - sb; c = (a < b); upd = 1; we = 0; end
      default: we = 0;
    endcase
    r = ((s % 65536) + 65536) % 65536;
    res = r[15:0];
    fout = fin;
    if (upd) begin
      n = (r >= 32768);
      z = (r == 0);
      f = (ss > 32767) || (ss < -32768);
      fout = {n, z, f, c};
    end
  endfunction

  task automatic setReg(input int idx, input int val);
    pl_idx = idx[4:0];
    pl_val = val[15:0];
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    model_rf[idx] = val[15:0];
  endtask

  // Issue one instruction and follow it cycle by cycle to retirement.
  task automatic applyStimulus(input logic [23:0] ins);
    int op, rd, rs, imm, guard;
    logic [15:0] eres;
    bit ewe;
    logic [3:0] efl;
    op  = int'(ins[23:20]);
    rd  = int'(ins[19:15]);
    rs  = int'(ins[14:10]);
    imm = int'(ins[7:0]);
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", 32'(instr_ready), 32'd1);
    if (!instr_ready) return;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'($urandom);
    instr = 24'($urandom);
    checkOutput("read_ready", 32'(instr_ready), 32'd0);
    checkOutput("read_idx1", 32'(reg_index1), 32'(rd));
    checkOutput("read_idx2", 32'(reg_index2), 32'(rs));
    checkOutput("read_done", 32'(done), 32'd0);
    refModel(op, int'(model_rf[rd]), int'(model_rf[rs]), imm, model_flags, eres, ewe, efl);
    @(negedge clk);
    instr_valid = 1'($urandom);
    checkOutput("exec_wen", 32'(w_enable), 32'd0);
    checkOutput("exec_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("write_done", 32'(done), 32'd1);
    checkOutput("write_wen", 32'(w_enable), 32'(ewe));
    if (ewe) begin
      checkOutput("write_widx", 32'(w_index), 32'(rd));
      checkOutput("write_wdata", 32'(w_data), 32'(eres));
    end
    checkOutput("write_flags", 32'(flags), 32'(efl));
    checkOutput("write_idx1_hold", 32'(reg_index1), 32'(rd));
    obs_wdata = w_data;
    obs_flags = flags;
    model_flags = efl;
    if (ewe) model_rf[rd] = eres;
    @(negedge clk);
    checkOutput("idle_ready", 32'(instr_ready), 32'd1);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_wen", 32'(w_enable), 32'd0);
  endtask

  initial begin
    logic [23:0] stream [3];
    int hs_at [3];
    int idx, wn, hsn;
    bit hs, seen;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_val = '0;
    model_flags = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 32; i++) setReg(i, int'($urandom_range(0, 65535)));

    // Reset state.
    checkOutput("rst_ready", 32'(instr_ready), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_wen", 32'(w_enable), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_idx1", 32'(reg_index1), 32'd0);
    checkOutput("rst_wdata", 32'(w_data), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    checkOutput("rel_ready_high", 32'(instr_ready), 32'd1);

    // Directed cases.
    applyStimulus(mk(7, 3, 0, 0, 8'h7F));
    checkOutput("movi_const", 32'(obs_wdata), 32'h007F);
    checkOutput("movi_flags_const", 32'(obs_flags), 32'h0);

    setReg(1, 16'h7FFF);
    setReg(2, 16'h0001);
    applyStimulus(mk(0, 1, 2, 0, 0));
    checkOutput("add_const", 32'(obs_wdata), 32'h8000);
    checkOutput("add_flags_const", 32'(obs_flags), 32'b1010);

    setReg(4, 16'h0005);
    setReg(5, 16'h0005);
    applyStimulus(mk(9, 4, 5, 0, 0));
    checkOutput("cmp_flags_const", 32'(obs_flags), 32'b0100);
    applyStimulus(mk(2, 4, 5, 0, 0));
    checkOutput("and_flags_hold", 32'(obs_flags), 32'b0100);

    setReg(6, 16'h0010);
    applyStimulus(mk(6, 6, 0, 3, 8'hF0));
    checkOutput("addi_const", 32'(obs_wdata), 32'h0000);
    checkOutput("addi_flags_const", 32'(obs_flags), 32'b0101);

    setReg(7, 16'h0003);
    setReg(8, 16'h0013);
    applyStimulus(mk(8, 7, 8, 0, 0));
    checkOutput("lsh_const", 32'(obs_wdata), 32'h0018);

    applyStimulus(mk(12, 0, 1, 0, 0));
    checkOutput("nop_flags_hold", 32'(obs_flags), 32'b0101);

    // Continuous valid: three MOVIs accepted every four cycles.
    stream[0] = mk(7, 10, 0, 0, 8'h11);
    stream[1] = mk(7, 11, 0, 0, 8'h22);
    stream[2] = mk(7, 12, 0, 0, 8'h33);
    idx = 0; wn = 0; hsn = 0;
    instr = stream[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      hs = instr_valid && instr_ready;
      if (hs) begin
        if (hsn < 3) hs_at[hsn] = c;
        hsn++;
      end
      if (w_enable) begin
        if (wn < 3) begin
          checkOutput("stream_widx", 32'(w_index), 32'(10 + wn));
          checkOutput("stream_wdata", 32'(w_data), 32'(17 * (wn + 1)));
        end
        wn++;
      end
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx < 3) instr = stream[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checkOutput("stream_hs_count", 32'(hsn), 32'd3);
    checkOutput("stream_w_count", 32'(wn), 32'd3);
    checkOutput("stream_hs0", 32'(hs_at[0]), 32'd0);
    checkOutput("stream_hs1", 32'(hs_at[1]), 32'd4);
    checkOutput("stream_hs2", 32'(hs_at[2]), 32'd8);
    for (int k = 0; k < 3; k++) model_rf[10 + k] = 16'(17 * (k + 1));

    // Random instructions against the reference model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0)
        setReg(int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
      applyStimulus(mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255))));
    end

    // Reset during EXEC abandons the instruction and clears the flags.
    setReg(1, 16'h7FFF);
    setReg(2, 16'h0001);
    applyStimulus(mk(0, 1, 2, 0, 0));
    instr = mk(7, 9, 0, 0, 8'h55);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_flags", 32'(flags), 32'd0);
    checkOutput("midrst_ready", 32'(instr_ready), 32'd0);
    checkOutput("midrst_idx1", 32'(reg_index1), 32'd0);
    @(negedge clk);
    seen = w_enable || done;
    rst = 1'b0;
    model_flags = 4'b0000;
    @(negedge clk);
    checkOutput("midrst_ready_back", 32'(instr_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      seen = seen || w_enable || done;
      @(negedge clk);
    end
    checkOutput("midrst_no_retire", 32'(seen), 32'd0);
    applyStimulus(mk(5, 13, 9, 0, 0));
    applyStimulus(mk(1, 13, 2, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
